// File: rtl/seq_logic_pkg.sv
// -----------------------------------------------------------------------------
// seq_logic_pkg
// Shared definitions for the serial bitwise logic unit:
//   - 3-bit operation encodings (OP_AND .. OP_PASSA)
//   - FSM state type (IDLE, RUN, DONE)
// -----------------------------------------------------------------------------
package seq_logic_pkg;

    localparam logic [2:0] OP_AND   = 3'd0;
    localparam logic [2:0] OP_OR    = 3'd1;
    localparam logic [2:0] OP_XOR   = 3'd2;
    localparam logic [2:0] OP_NOR   = 3'd3;
    localparam logic [2:0] OP_ANDN  = 3'd4;  // a & ~b
    localparam logic [2:0] OP_ORN   = 3'd5;  // a | ~b
    localparam logic [2:0] OP_XNOR  = 3'd6;
    localparam logic [2:0] OP_PASSA = 3'd7;  // y = a

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/seq_logic_unit_slice.sv
// -----------------------------------------------------------------------------
// logic_slice
// Purely combinational W-bit bitwise operation mux.
// Ports:
//   a_i  [W-1:0]  operand A chunk
//   b_i  [W-1:0]  operand B chunk
//   op_i [2:0]    operation select (seq_logic_pkg OP_* encodings)
//   y_o  [W-1:0]  result chunk
// -----------------------------------------------------------------------------
module logic_slice
    import seq_logic_pkg::*;
#(
    parameter int W = 8
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic [2:0]   op_i,
    output logic [W-1:0] y_o
);

    always_comb begin
        y_o = '0;
        unique case (op_i)
            OP_AND:   y_o = a_i & b_i;
            OP_OR:    y_o = a_i | b_i;
            OP_XOR:   y_o = a_i ^ b_i;
            OP_NOR:   y_o = ~(a_i | b_i);
            OP_ANDN:  y_o = a_i & ~b_i;
            OP_ORN:   y_o = a_i | ~b_i;
            OP_XNOR:  y_o = ~(a_i ^ b_i);
            OP_PASSA: y_o = a_i;
            default:  y_o = '0;
        endcase
    end

endmodule

// File: rtl/seq_logic_unit.sv
// -----------------------------------------------------------------------------
// seq_logic_unit
// Multi-mode bitwise logic unit that processes N-bit operands serially,
// CHUNK bits per cycle (LSB chunk first), behind valid/ready handshakes.
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   request valid (a, b, op presented)
//   in_ready   unit accepts a request (IDLE only)
//   a, b [N-1:0]  operands
//   op   [2:0]    operation select
//   out_valid  result valid (DONE)
//   out_ready  consumer accepts result
//   y    [N-1:0]  result
//   zero       high when y == 0 (meaningful only while out_valid)
// -----------------------------------------------------------------------------
module seq_logic_unit
    import seq_logic_pkg::*;
#(
    parameter int N     = 32,
    parameter int CHUNK = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [2:0]   op,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] y,
    output logic         zero
);

    localparam int BEATS = N / CHUNK;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    if ((N % CHUNK) != 0) begin : g_width_check
        $error("seq_logic_unit: N (%0d) must be a multiple of CHUNK (%0d)", N, CHUNK);
    end

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [N-1:0]       a_q, a_d;
    logic [N-1:0]       b_q, b_d;
    logic [2:0]         op_q, op_d;
    logic [N-1:0]       y_q, y_d;
    logic               nz_q, nz_d;

    logic [CHUNK-1:0]   chunk_a;
    logic [CHUNK-1:0]   chunk_b;
    logic [CHUNK-1:0]   chunk_y;

    assign chunk_a = a_q[cnt_q*CHUNK +: CHUNK];
    assign chunk_b = b_q[cnt_q*CHUNK +: CHUNK];

    logic_slice #(
        .W (CHUNK)
    ) u_slice (
        .a_i  (chunk_a),
        .b_i  (chunk_b),
        .op_i (op_q),
        .y_o  (chunk_y)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        y_d     = y_q;
        nz_d    = nz_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    op_d    = op;
                    cnt_d   = '0;
                    y_d     = '0;
                    nz_d    = 1'b0;
                    state_d = RUN;
                end
            end
            RUN: begin
                y_d[cnt_q*CHUNK +: CHUNK] = chunk_y;
                nz_d  = nz_q | (|chunk_y);
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_BEAT) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control and visible result state: reset so that an interrupted
    // transfer leaves no partial output behind.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            y_q     <= '0;
            nz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            y_q     <= y_d;
            nz_q    <= nz_d;
        end
    end

    // Operand latches are pure data; they are always rewritten on accept.
    always_ff @(posedge clk) begin
        a_q  <= a_d;
        b_q  <= b_d;
        op_q <= op_d;
    end

    // Handshake outputs come from the state register only.
    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign y         = y_q;
    assign zero      = ~nz_q;

endmodule

// File: tb/tb_seq_logic_unit.sv
module tb_seq_logic_unit;

    logic        clk;
    logic        rst;

    // Serial configuration: N=32, CHUNK=8
    logic        in_valid, in_ready, out_valid, out_ready, zero;
    logic [31:0] a, b, y;
    logic [2:0]  op;

    // Single-beat configuration: N=CHUNK=32
    logic        s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_zero;
    logic [31:0] s_a, s_b, s_y;
    logic [2:0]  s_op;

    int n_cmp  = 0;
    int n_fail = 0;

    seq_logic_unit #(.N(32), .CHUNK(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .zero      (zero)
    );

    seq_logic_unit #(.N(32), .CHUNK(32)) dut1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (s_in_valid),
        .in_ready  (s_in_ready),
        .a         (s_a),
        .b         (s_b),
        .op        (s_op),
        .out_valid (s_out_valid),
        .out_ready (s_out_ready),
        .y         (s_y),
        .zero      (s_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one request into the serial DUT and measures it. lat is the
    // number of edges from accept to out_valid (-1 on timeout); rdy_viol
    // counts samples where in_ready was high between accept and DONE.
    task automatic issue(input logic [31:0] ta, input logic [31:0] tb,
                         input logic [2:0] top, input logic ordy,
                         output int lat, output int rdy_viol,
                         output logic [31:0] ry, output logic rz);
        int w;
        w = 0;
        while (!in_ready && w < 20) begin
            tick();
            w++;
        end
        a = ta; b = tb; op = top; in_valid = 1'b1; out_ready = ordy;
        tick();
        in_valid = 1'b0;
        a = ~ta; b = ta ^ tb; op = ~top;
        lat = -1; rdy_viol = 0; ry = 'x; rz = 1'bx;
        if (in_ready) rdy_viol++;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (in_ready) rdy_viol++;
            if (out_valid) begin
                lat = i; ry = y; rz = zero;
                break;
            end
        end
        if (ordy && lat > 0) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        n_cmp++; if (y !== 32'h0) begin n_fail++; $display("FAIL reset_y got=%h want=00000000", y); end
        n_cmp++; if (zero !== 1'b1) begin n_fail++; $display("FAIL reset_zero got=%b want=1", zero); end
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
        n_cmp++; if (s_in_ready !== 1'b1 || s_out_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_single got rdy=%b vld=%b want rdy=1 vld=0", s_in_ready, s_out_valid);
        end
    endtask

    task automatic test_and_latency();
        int lat, rv; logic [31:0] ry; logic rz;
        issue(32'hF0F0_AAAA, 32'hFF00_5555, 3'd0, 1'b1, lat, rv, ry, rz);
        n_cmp++; if (lat !== 4) begin n_fail++; $display("FAIL and_latency got=%0d want=4", lat); end
        n_cmp++; if (ry !== 32'hF000_0000) begin n_fail++; $display("FAIL and_y got=%h want=f0000000", ry); end
        n_cmp++; if (rz !== 1'b0) begin n_fail++; $display("FAIL and_zero got=%b want=0", rz); end
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL and_idle_after got=%b want=1", in_ready); end
    endtask

    task automatic test_back_to_back();
        logic [2:0]  ops  [3] = '{3'd2, 3'd3, 3'd5};
        logic [31:0] exps [3] = '{32'h0FF0_FFFF, 32'h000F_0000, 32'hF0FF_AAAA};
        int lat, rv; logic [31:0] ry; logic rz;
        for (int k = 0; k < 3; k++) begin
            issue(32'hF0F0_AAAA, 32'hFF00_5555, ops[k], 1'b1, lat, rv, ry, rz);
            n_cmp++; if (ry !== exps[k]) begin n_fail++; $display("FAIL b2b_y[%0d] got=%h want=%h", k, ry, exps[k]); end
            n_cmp++; if (lat !== 4) begin n_fail++; $display("FAIL b2b_latency[%0d] got=%0d want=4", k, lat); end
            n_cmp++; if (rv !== 0) begin n_fail++; $display("FAIL b2b_in_ready_busy[%0d] got=%0d want=0", k, rv); end
        end
    endtask

    task automatic test_zero_flag();
        int lat, rv; logic [31:0] ry; logic rz;
        issue(32'h1234_5678, 32'h1234_5678, 3'd2, 1'b1, lat, rv, ry, rz);
        n_cmp++; if (ry !== 32'h0) begin n_fail++; $display("FAIL xor_self_y got=%h want=00000000", ry); end
        n_cmp++; if (rz !== 1'b1) begin n_fail++; $display("FAIL xor_self_zero got=%b want=1", rz); end
        issue(32'h1234_5678, 32'h1234_5678, 3'd6, 1'b1, lat, rv, ry, rz);
        n_cmp++; if (ry !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL xnor_self_y got=%h want=ffffffff", ry); end
        n_cmp++; if (rz !== 1'b0) begin n_fail++; $display("FAIL xnor_self_zero got=%b want=0", rz); end
    endtask

    task automatic test_backpressure();
        int lat, rv; logic [31:0] ry; logic rz;
        int bad;
        // ANDN: F0F0AAAA & ~FF005555 = F0F0AAAA & 00FFAAAA = 00F0AAAA
        issue(32'hF0F0_AAAA, 32'hFF00_5555, 3'd4, 1'b0, lat, rv, ry, rz);
        n_cmp++; if (ry !== 32'h00F0_AAAA) begin n_fail++; $display("FAIL bp_y got=%h want=00f0aaaa", ry); end
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            in_valid = ~in_valid;
            a = $urandom; b = $urandom; op = 3'($urandom);
            tick();
            if (out_valid !== 1'b1 || y !== 32'h00F0_AAAA || zero !== 1'b0 || in_ready !== 1'b0) bad++;
        end
        n_cmp++; if (bad !== 0) begin n_fail++; $display("FAIL bp_hold got=%0d unstable cycles want=0", bad); end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++; $display("FAIL bp_release got vld=%b rdy=%b want vld=0 rdy=1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset_mid_run();
        int lat, rv; logic [31:0] ry; logic rz;
        a = 32'h1111_1111; b = 32'h2222_2222; op = 3'd1; in_valid = 1'b1; out_ready = 1'b1;
        tick();           // accept
        in_valid = 1'b0;
        tick();           // cnt 0 -> 1
        tick();           // cnt 1 -> 2
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_out_valid got=%b want=0", out_valid); end
        n_cmp++; if (y !== 32'h0) begin n_fail++; $display("FAIL midrst_y got=%h want=00000000", y); end
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_in_ready got=%b want=1", in_ready); end
        issue(32'hF0F0_AAAA, 32'hFF00_5555, 3'd0, 1'b1, lat, rv, ry, rz);
        n_cmp++; if (ry !== 32'hF000_0000 || lat !== 4) begin
            n_fail++; $display("FAIL midrst_fresh got y=%h lat=%0d want y=f0000000 lat=4", ry, lat);
        end
    endtask

    task automatic test_single_beat();
        s_a = 32'hDEAD_BEEF; s_b = 32'h0000_0000; s_op = 3'd7; s_in_valid = 1'b1; s_out_ready = 1'b0;
        tick();           // accept
        s_in_valid = 1'b0;
        s_a = 32'h0; s_op = 3'd0;
        n_cmp++; if (s_out_valid !== 1'b0 || s_in_ready !== 1'b0) begin
            n_fail++; $display("FAIL single_run got vld=%b rdy=%b want vld=0 rdy=0", s_out_valid, s_in_ready);
        end
        tick();
        n_cmp++; if (s_out_valid !== 1'b1) begin n_fail++; $display("FAIL single_latency got vld=%b want=1", s_out_valid); end
        n_cmp++; if (s_y !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL single_y got=%h want=deadbeef", s_y); end
        n_cmp++; if (s_zero !== 1'b0) begin n_fail++; $display("FAIL single_zero got=%b want=0", s_zero); end
        s_out_ready = 1'b1;
        tick();
        n_cmp++; if (s_in_ready !== 1'b1 || s_out_valid !== 1'b0) begin
            n_fail++; $display("FAIL single_idle got rdy=%b vld=%b want rdy=1 vld=0", s_in_ready, s_out_valid);
        end
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; op = '0;
        s_in_valid = 1'b0; s_out_ready = 1'b0; s_a = '0; s_b = '0; s_op = '0;
        test_reset();
        test_and_latency();
        test_back_to_back();
        test_zero_flag();
        test_backpressure();
        test_reset_mid_run();
        test_single_beat();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
